mash_combiner: RTL
==================

MASH_COMBINER -- requirements
Module: mash_combiner

Interface
REQ-001 Parameter ORDER, default 3, is the modulator order and SHALL be legal in the range 1..3; any other value is a synthesis error.
REQ-002 Parameter NW, default 8, is the width of the integer divide value and of div_out.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 en  input  1  is the sample enable; c1/c2/c3 are consumed only on edges where en=1.
REQ-006 c1  input  1  is the carry from mash_stage #1.
REQ-007 c2  input  1  is the carry from mash_stage #2, which is fed by the e_out of stage #1.
REQ-008 c3  input  1  is the carry from mash_stage #3, which is fed by the e_out of stage #2.
REQ-009 n_int  input  NW  is the unsigned integer part of the divide ratio.
REQ-010 y  output  4  is the signed two's-complement noise-shaped fractional offset, registered.
REQ-011 div_out  output  NW  is the unsigned divide value n_int+y after saturation, registered.
REQ-012 out_valid  output  1  is high when y/div_out hold a fully warmed-up sample.
REQ-013 sat  output  1  is high for the cycle in which div_out was clamped.
REQ-014 sat_cnt  output  16  is the number of clamp events since reset, saturating at 0xFFFF.

Function
REQ-015 Let x[k] denote the input value at the k-th enabled edge after reset; history terms with k<0 SHALL read as 0.
REQ-016 For ORDER=3, at enabled edge k: y = c1[k-2] + c2[k-1] - c2[k-2] + c3[k] - 2*c3[k-1] + c3[k-2].
REQ-017 For ORDER=2, at enabled edge k: y = c1[k-1] + c2[k] - c2[k-1]; c3 is ignored.
REQ-018 For ORDER=1, at enabled edge k: y = c1[k]; c2 and c3 are ignored.
REQ-019 Latency: y, div_out and sat SHALL reflect sample k immediately after the edge that samples k, i.e. one register stage.
REQ-020 The range of y is -3..+4; the arithmetic SHALL be signed and at least 4 bits wide with no internal wrap.
REQ-021 div_out SHALL be computed in NW+2-bit signed arithmetic, then clamped to 0..2^NW-1.
REQ-022 sat SHALL be 1 when the clamp is active on that edge and 0 otherwise.
REQ-023 sat_cnt SHALL increment by 1 on every enabled edge with sat=1 and SHALL hold at 0xFFFF once it reaches that value.
REQ-024 A warm-up counter SHALL count enabled edges, saturating at ORDER-1.
REQ-025 out_valid SHALL be 1 after enabled edge k if and only if k >= ORDER-1.
REQ-026 On an edge with en=0:
- the history registers, y, div_out, the warm-up counter and sat_cnt SHALL hold;
- out_valid and sat SHALL be 0.
REQ-027 A change of n_int SHALL take effect at the next enabled edge without disturbing the history registers.

Reset
REQ-028 When rst=1 at a rising edge, the following SHALL all become 0, regardless of en and of the other inputs: history registers, warm-up counter, y, div_out, out_valid, sat and sat_cnt.
REQ-029 A rst pulse in mid-stream SHALL restart the sequence at k=0, so that out_valid is low for the next ORDER-1 enabled edges.
REQ-030 rst SHALL take priority over en.

Verification
REQ-031 rst=1 for 3 cycles with en=1, c1=c2=c3=1, n_int=0xFF -> y=0, div_out=0, out_valid=0, sat=0, sat_cnt=0.
REQ-032 ORDER=3, n_int=10, c1=1, c2=c3=0, en=1 -> y=0,0,1,1...; div_out=10,10,11,11...; out_valid first high after edge k=2.
REQ-033 ORDER=3, n_int=10, c1=c2=0, c3=1 only at k=5 -> y at k=5,6,7 = +1,-2,+1; div_out=11,8,11; y=0 at all other k.
REQ-034 ORDER=3, n_int=1, c3 impulse at k=5 -> div_out at k=5,6,7 = 2,0,2; sat=1 only at k=6; sat_cnt=1.
REQ-035 ORDER=3, c1=c2=c3=1 constant, n_int=20, with en=0 for 3 cycles after k=4:
- during the gap: y and div_out hold 1/21, out_valid=0;
- after the gap: steady y=1 resumes with no transient.
REQ-036 With rst asserted for 1 cycle at k=6 in the REQ-032 stream -> out_valid is low for the next 2 enabled edges and y restarts at 0,0,1.

Source files
------------

// File: rtl/mash_combiner.sv
// Noise-cancellation combiner for a cascaded MASH 1-1-1 sigma-delta modulator:
// merges stage carries into a signed offset and forms the saturated divide value.
module mash_combiner #(
  parameter int ORDER = 3,
  parameter int NW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                c1,
  input  logic                c2,
  input  logic                c3,
  input  logic [NW-1:0]       n_int,
  output logic signed [3:0]   y,
  output logic [NW-1:0]       div_out,
  output logic                out_valid,
  output logic                sat,
  output logic [15:0]         sat_cnt
);

  generate
    if (ORDER < 1 || ORDER > 3) begin : g_bad_order
      $error("mash_combiner: ORDER must be 1..3");
    end
  endgenerate

  localparam logic [1:0] WU_MAX = 2'(ORDER - 1);

  logic               c1_d1_r, c1_d2_r;
  logic               c2_d1_r, c2_d2_r;
  logic               c3_d1_r, c3_d2_r;
  logic [1:0]         wu_cnt_r;
  logic signed [5:0]  y_sum_s;
  logic signed [NW+1:0] div_sum_s;
  logic [NW-1:0]      div_clamp_s;
  logic               clamp_s;

  // Difference network: each later stage is differentiated one more time
  always_comb begin
    y_sum_s = 6'sd0;
    case (ORDER)
      32'sd1: y_sum_s = $signed({5'd0, c1});
      32'sd2: y_sum_s = $signed({5'd0, c1_d1_r}) + $signed({5'd0, c2})
                      - $signed({5'd0, c2_d1_r});
      32'sd3: y_sum_s = $signed({5'd0, c1_d2_r})
                      + $signed({5'd0, c2_d1_r}) - $signed({5'd0, c2_d2_r})
                      + $signed({5'd0, c3}) - $signed({4'd0, c3_d1_r, 1'b0})
                      + $signed({5'd0, c3_d2_r});
      default: y_sum_s = 6'sd0;
    endcase
  end

  assign div_sum_s = $signed({2'b00, n_int}) + (NW + 2)'(y_sum_s);

  // Clamp the widened sum into the unsigned divide range
  always_comb begin
    div_clamp_s = div_sum_s[NW-1:0];
    clamp_s     = 1'b0;
    if (div_sum_s[NW+1]) begin
      div_clamp_s = {NW{1'b0}};
      clamp_s     = 1'b1;
    end else if (div_sum_s[NW]) begin
      div_clamp_s = {NW{1'b1}};
      clamp_s     = 1'b1;
    end else begin
      div_clamp_s = div_sum_s[NW-1:0];
      clamp_s     = 1'b0;
    end
  end

  // Carry history, warm-up tracking and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_d1_r   <= 1'b0;
      c1_d2_r   <= 1'b0;
      c2_d1_r   <= 1'b0;
      c2_d2_r   <= 1'b0;
      c3_d1_r   <= 1'b0;
      c3_d2_r   <= 1'b0;
      wu_cnt_r  <= 2'd0;
      y         <= 4'sd0;
      div_out   <= {NW{1'b0}};
      out_valid <= 1'b0;
      sat       <= 1'b0;
      sat_cnt   <= 16'd0;
    end else if (en) begin
      c1_d1_r   <= c1;
      c1_d2_r   <= c1_d1_r;
      c2_d1_r   <= c2;
      c2_d2_r   <= c2_d1_r;
      c3_d1_r   <= c3;
      c3_d2_r   <= c3_d1_r;
      wu_cnt_r  <= (wu_cnt_r == WU_MAX) ? wu_cnt_r : wu_cnt_r + 2'd1;
      y         <= y_sum_s[3:0];
      div_out   <= div_clamp_s;
      out_valid <= (wu_cnt_r == WU_MAX);
      sat       <= clamp_s;
      sat_cnt   <= (clamp_s && sat_cnt != 16'hFFFF) ? sat_cnt + 16'd1 : sat_cnt;
    end else begin
      // Idle edge: state holds, per-sample strobes drop
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end
  end

endmodule
